// File: rtl/a2d_sched_pkg.sv
// Shared types, channel addresses and command-word helper for the A2D round-robin scheduler.
package a2d_sched_pkg;

  typedef enum logic [1:0] {StIdle, StCmd, StGap, StRd} state_t;

  typedef logic [1:0] rr_idx_t;

  localparam logic [2:0] ChLft   = 3'd0;
  localparam logic [2:0] ChRght  = 3'd4;
  localparam logic [2:0] ChSteer = 3'd5;
  localparam logic [2:0] ChBatt  = 3'd6;

  function automatic logic [2:0] idx_to_ch(rr_idx_t idx);
    logic [2:0] ch;
    ch = ChLft;
    unique case (idx)
      2'd0: ch = ChLft;
      2'd1: ch = ChRght;
      2'd2: ch = ChSteer;
      2'd3: ch = ChBatt;
      default: ch = ChLft;
    endcase
    return ch;
  endfunction

  function automatic logic [15:0] mk_cmd(logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_cyc_timer.sv
// Clear/enable cycle counter with terminal-count compare; shared by the gap and timeout windows.
module a2d_cyc_timer #(
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [Width-1:0] tc,
  output logic             last
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last = (cnt_q == tc);

endmodule

// File: rtl/a2d_rr_sched.sv
// Round-robin A2D scheduler: one cmd + one read SPI transaction per conversion over four channels.
// Optional SPI timeout with sticky err is enabled by defining A2D_TIMEOUT_EN.
module a2d_rr_sched
  import a2d_sched_pkg::*;
#(
  parameter int unsigned GapCyc     = 4,
  parameter int unsigned TimeoutCyc = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        conv_vld,
  output logic [1:0]  conv_idx,
  output logic        busy,
  output logic        err
);

  localparam int unsigned TmrMax = (TimeoutCyc > GapCyc) ? TimeoutCyc : GapCyc;
  localparam int unsigned TmrW   = (TmrMax < 2) ? 1 : $clog2(TmrMax);
  localparam logic [TmrW-1:0] GapTc = TmrW'(GapCyc - 1);

  state_t      state_q, state_d;
  rr_idx_t     idx_q, idx_d;
  logic        pend_q, pend_d;
  logic        wrt_q, wrt_d;
  logic [15:0] cmd_q, cmd_d;
  logic        vld_q, vld_d;
  rr_idx_t     cidx_q, cidx_d;
  logic [11:0] lft_q, rght_q, steer_q, batt_q;
  logic        cap;
  logic        tmr_clr, tmr_en, tmr_last;
  logic [TmrW-1:0] tmr_tc;
  logic        unused_rd_hi;

  assign unused_rd_hi = ^spi_rd_data[15:12];

`ifdef A2D_TIMEOUT_EN
  localparam logic [TmrW-1:0] TimeoutTc = TmrW'(TimeoutCyc - 1);
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    vld_d   = 1'b0;
    cidx_d  = cidx_q;
    cap     = 1'b0;
    tmr_en  = 1'b0;
    tmr_tc  = GapTc;
`ifdef A2D_TIMEOUT_EN
    err_d   = err_q;
`endif
    // A request arriving on the clock busy falls still lands in pend.
    if (nxt && (state_q != StIdle)) pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (nxt || pend_q) begin
          wrt_d   = 1'b1;
          cmd_d   = mk_cmd(idx_to_ch(idx_q));
          pend_d  = 1'b0;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (spi_done) begin
          state_d = StGap;
        end
`ifdef A2D_TIMEOUT_EN
        else begin
          tmr_en = 1'b1;
          tmr_tc = TimeoutTc;
          if (tmr_last) begin
            err_d   = 1'b1;
            idx_d   = idx_q + 1'b1;
            state_d = StIdle;
          end
        end
`endif
      end
      StGap: begin
        tmr_en = 1'b1;
        if (tmr_last) begin
          wrt_d   = 1'b1;
          state_d = StRd;
        end
      end
      StRd: begin
        if (spi_done) begin
          cap     = 1'b1;
          vld_d   = 1'b1;
          cidx_d  = idx_q;
          idx_d   = idx_q + 1'b1;
          state_d = StIdle;
        end
`ifdef A2D_TIMEOUT_EN
        else begin
          tmr_en = 1'b1;
          tmr_tc = TimeoutTc;
          if (tmr_last) begin
            err_d   = 1'b1;
            idx_d   = idx_q + 1'b1;
            state_d = StIdle;
          end
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    // Every state change restarts the shared window count.
    tmr_clr = (state_d != state_q);
  end

  a2d_cyc_timer #(
    .Width (TmrW)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .tc   (tmr_tc),
    .last (tmr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      wrt_q   <= 1'b0;
      cmd_q   <= '0;
      vld_q   <= 1'b0;
      cidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      wrt_q   <= wrt_d;
      cmd_q   <= cmd_d;
      vld_q   <= vld_d;
      cidx_q  <= cidx_d;
    end
  end

  // Battery resets to full scale so downstream logic sees no low-battery alarm.
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_q   <= '0;
      rght_q  <= '0;
      steer_q <= '0;
      batt_q  <= 12'hFFF;
    end else if (cap) begin
      unique case (idx_q)
        2'd0: lft_q   <= spi_rd_data[11:0];
        2'd1: rght_q  <= spi_rd_data[11:0];
        2'd2: steer_q <= spi_rd_data[11:0];
        2'd3: batt_q  <= spi_rd_data[11:0];
        default: lft_q <= lft_q;
      endcase
    end
  end

`ifdef A2D_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign spi_wrt   = wrt_q;
  assign spi_cmd   = cmd_q;
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;
  assign conv_vld  = vld_q;
  assign conv_idx  = cidx_q;
  assign busy      = (state_q != StIdle);

endmodule
